// File: rtl/fft_pkg.sv
// Shared FFT control definitions: default transform geometry and the control
// state encoding used by the FFT stage sequencing blocks.
package fft_pkg;

  localparam int FFT_N          = 8;
  localparam int FFT_LOG2N      = $clog2(FFT_N);
  localparam int FFT_STAGE_W    = $clog2(FFT_LOG2N);
  localparam int FFT_BF_LATENCY = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft_ctl_state_t;

endpackage

// File: rtl/fft_stage_sequencer.sv
// Walks every FFT stage and every sample index, presenting (index, stage) pairs
// over valid/ready with a butterfly drain gap between stages.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N          = FFT_N,
  parameter int LOG2N      = $clog2(N),
  parameter int STAGE_W    = $clog2(LOG2N),
  parameter int BF_LATENCY = FFT_BF_LATENCY
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ready_in,
  output logic               valid_out,
  output logic [LOG2N-1:0]   index_out,
  output logic [STAGE_W-1:0] stage_out,
  output logic               last_out,
  output logic               busy,
  output logic               done
);

  localparam int DRAIN_W = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
  localparam logic [LOG2N-1:0]   IDX_MAX    = LOG2N'(N - 1);
  localparam logic [STAGE_W-1:0] STAGE_MAX  = STAGE_W'(LOG2N - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'((BF_LATENCY > 0) ? BF_LATENCY - 1 : 0);

  fft_ctl_state_t       state_r, state_s;
  logic [LOG2N-1:0]     index_r, index_s;
  logic [STAGE_W-1:0]   stage_r, stage_s;
  logic [DRAIN_W-1:0]   drain_r, drain_s;
  logic                 valid_s, last_s, busy_s, done_s;

  // Next-state, counter and output decode; outputs are computed from the next
  // state so they can be registered alongside it.
  always_comb begin
    state_s = state_r;
    index_s = index_r;
    stage_s = stage_r;
    drain_s = drain_r;
    case (state_r)
      ST_IDLE: begin
        index_s = '0;
        stage_s = '0;
        drain_s = '0;
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (valid_out && ready_in) begin
          if (index_r != IDX_MAX) begin
            index_s = index_r + 1'b1;
          end else if (stage_r == STAGE_MAX) begin
            state_s = ST_DONE;
          end else if (BF_LATENCY > 0) begin
            state_s = ST_DRAIN;
            drain_s = DRAIN_INIT;
          end else begin
            index_s = '0;
            stage_s = stage_r + 1'b1;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Index holds at N-1 until the butterfly writes of this stage retire.
        if (drain_r == '0) begin
          state_s = ST_RUN;
          index_s = '0;
          stage_s = stage_r + 1'b1;
        end else begin
          drain_s = drain_r - 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        index_s = '0;
        stage_s = '0;
        drain_s = '0;
      end
      default: begin
        state_s = ST_IDLE;
        index_s = '0;
        stage_s = '0;
        drain_s = '0;
      end
    endcase
    valid_s = (state_s == ST_RUN);
    last_s  = (state_s == ST_RUN) && (index_s == IDX_MAX);
    busy_s  = (state_s != ST_IDLE);
    done_s  = (state_s == ST_DONE);
  end

  // State, counters and all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      index_r   <= '0;
      stage_r   <= '0;
      drain_r   <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      index_r   <= index_s;
      stage_r   <= stage_s;
      drain_r   <= drain_s;
      valid_out <= valid_s;
      last_out  <= last_s;
      busy      <= busy_s;
      done      <= done_s;
    end
  end

  assign index_out = index_r;
  assign stage_out = stage_r;

endmodule
